// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: receive-side seven-segment decoder for a two-digit FND pair.
// Samples {seg1,seg0} every clock and waits until the pair has held for
// STABLE_CYCLES clocks. It then decodes the pair to BCD and binary, pulses
// out_valid for one cycle, and holds the result until the next report.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   seg1       in   8  tens-digit segments {dp,g,f,e,d,c,b,a}, active-high
//   seg0       in   8  ones-digit segments, same encoding
//   out_valid  out  1  one-cycle pulse when a new stable pair is decoded
//   out_err    out  1  last reported pair contained an illegal pattern
//   tens       out  4  decoded tens digit (4'hF on error)
//   ones       out  4  decoded ones digit (4'hF on error)
//   bin        out  7  tens*10 + ones (7'h7F on error)
//   stable     out  1  high while the reported pair is still on the inputs
module fnd_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg1,
  input  logic [7:0] seg0,
  output logic       out_valid,
  output logic       out_err,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] bin,
  output logic       stable
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } state_e;

  state_e           state_q;
  logic [15:0]      samp_q;
  logic [15:0]      samp_d;
  logic [CNT_W-1:0] cnt_q;
  logic             primed_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic [3:0]       tens_q;
  logic [3:0]       ones_q;
  logic             stable_q;

  logic             chg_c;
  logic [4:0]       dec_tens_c;
  logic [4:0]       dec_ones_c;
  logic             dec_err_c;
  logic [6:0]       tens7_c;
  logic [6:0]       sum_c;

  // Segment code (dp already dropped) to {illegal, digit}.
  // blank_ok lets an all-off pattern decode as 0 (used for a blank tens digit).
  function automatic logic [4:0] dec_digit(input logic [6:0] code, input logic blank_ok);
    logic [4:0] r;
    r = 5'h1F;
    case (code)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h00: r = blank_ok ? 5'h00 : 5'h1F;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Change detect and decode of the registered sample (equal to the input on an emitting edge).
  always_comb begin
    samp_d     = {seg1, seg0};
    // The first edge after reset always counts as a change, so the pair present at release is reported.
    chg_c      = !primed_q || (samp_d != samp_q);
    dec_tens_c = dec_digit(samp_q[14:8], 1'b1);
    dec_ones_c = dec_digit(samp_q[6:0], 1'b0);
    dec_err_c  = dec_tens_c[4] | dec_ones_c[4];
  end

  // Settle/hold controller with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      samp_q      <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      tens_q      <= '0;
      ones_q      <= '0;
      stable_q    <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      primed_q    <= 1'b1;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_SETTLE: begin
          if (chg_c) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // Counter is parked at its full value while holding so it cannot wrap.
            cnt_q       <= CNT_FULL;
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
            stable_q    <= 1'b1;
            out_err_q   <= dec_err_c;
            tens_q      <= dec_err_c ? 4'hF : dec_tens_c[3:0];
            ones_q      <= dec_err_c ? 4'hF : dec_ones_c[3:0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (chg_c) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SETTLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Binary value from the registered digits: tens*8 + tens*2 + ones.
  always_comb begin
    tens7_c = 7'(tens_q);
    sum_c   = (tens7_c << 3) + (tens7_c << 1) + 7'(ones_q);
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign tens      = tens_q;
  assign ones      = ones_q;
  assign bin       = out_err_q ? 7'h7F : sum_c;
  assign stable    = stable_q;

endmodule

// File: tb/tb_fnd_seg_decoder.sv
// tb_fnd_seg_decoder: directed self-checking bench for fnd_seg_decoder.
module tb_fnd_seg_decoder;

  localparam int unsigned SC = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg1;
  logic [7:0] seg0;
  logic       out_valid;
  logic       out_err;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] bin;
  logic       stable;

  int vectors;
  int miscompares;

  fnd_seg_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg1      (seg1),
    .seg0      (seg0),
    .out_valid (out_valid),
    .out_err   (out_err),
    .tens      (tens),
    .ones      (ones),
    .bin       (bin),
    .stable    (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table for a decimal digit.
  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] s;
    case (d)
      0: s = 8'h3F;
      1: s = 8'h06;
      2: s = 8'h5B;
      3: s = 8'h4F;
      4: s = 8'h66;
      5: s = 8'h6D;
      6: s = 8'h7D;
      7: s = 8'h07;
      8: s = 8'h7F;
      default: s = 8'h6F;
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects no pulse on the change edge and the SC-1 edges after it, then one report.
  task automatic expect_report(input string tag, input logic [3:0] t, input logic [3:0] o,
                               input logic [6:0] b, input logic e);
    for (int i = 0; i < int'(SC); i++) begin
      tick();
      chk({tag, "_nopulse"}, 16'(out_valid), 16'h0);
    end
    tick();
    chk({tag, "_valid"}, 16'(out_valid), 16'h1);
    chk({tag, "_tens"}, 16'(tens), 16'(t));
    chk({tag, "_ones"}, 16'(ones), 16'(o));
    chk({tag, "_bin"}, 16'(bin), 16'(b));
    chk({tag, "_err"}, 16'(out_err), 16'(e));
    chk({tag, "_stable"}, 16'(stable), 16'h1);
    tick();
    chk({tag, "_pulse_end"}, 16'(out_valid), 16'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 16'(out_valid), 16'h0);
    chk({tag, "_err"}, 16'(out_err), 16'h0);
    chk({tag, "_tens"}, 16'(tens), 16'h0);
    chk({tag, "_ones"}, 16'(ones), 16'h0);
    chk({tag, "_bin"}, 16'(bin), 16'h0);
    chk({tag, "_stable"}, 16'(stable), 16'h0);
  endtask

  initial begin
    int sum;
    int pulses;
    logic [6:0] bin_seen;
    logic err_seen;

    vectors     = 0;
    miscompares = 0;

    // Reset, then first report of "29".
    rst_n = 1'b0;
    seg1  = 8'h5B;
    seg0  = 8'h6F;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    expect_report("first29", 4'd2, 4'd9, 7'd29, 1'b0);
    tick();
    chk("first29_once", 16'(out_valid), 16'h0);
    chk("first29_hold_stable", 16'(stable), 16'h1);

    // Blank tens with dp set on the ones digit.
    seg1 = 8'h00;
    seg0 = 8'h86;
    expect_report("blank_dp", 4'd0, 4'd1, 7'd1, 1'b0);

    // Illegal: blank ones, then a bad tens pattern.
    seg1 = 8'h06;
    seg0 = 8'h00;
    expect_report("ill_blank1", 4'hF, 4'hF, 7'h7F, 1'b1);
    seg1 = 8'h12;
    seg0 = 8'h3F;
    expect_report("ill_tens", 4'hF, 4'hF, 7'h7F, 1'b1);

    // Glitch rejection around "30".
    seg1 = 8'h4F;
    seg0 = 8'h3F;
    expect_report("g30", 4'd3, 4'd0, 7'd30, 1'b0);
    seg1 = 8'h7F;
    tick();
    chk("glitch_stable_drop", 16'(stable), 16'h0);
    chk("glitch_bin_frozen", 16'(bin), 16'd30);
    tick();
    chk("glitch_nopulse1", 16'(out_valid), 16'h0);
    tick();
    chk("glitch_nopulse2", 16'(out_valid), 16'h0);
    chk("glitch_tens_frozen", 16'(tens), 16'd3);
    seg1 = 8'h4F;
    expect_report("g30_ret", 4'd3, 4'd0, 7'd30, 1'b0);

    // Change exactly on the edge that would have emitted "11".
    seg1 = 8'h06;
    seg0 = 8'h06;
    for (int i = 0; i < int'(SC); i++) begin
      tick();
      chk("emitedge_nopulse", 16'(out_valid), 16'h0);
    end
    seg1 = 8'h5B;
    seg0 = 8'h5B;
    expect_report("emitedge_22", 4'd2, 4'd2, 7'd22, 1'b0);

    // Adder-sweep loopback: b changes every SC+1 clocks.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        sum    = a + b;
        seg1   = (sum / 10 == 0) ? 8'h00 : seg_of(sum / 10);
        seg0   = seg_of(sum % 10);
        pulses = 0;
        bin_seen = 7'h00;
        err_seen = 1'b0;
        for (int i = 0; i <= int'(SC); i++) begin
          tick();
          if (out_valid) begin
            pulses++;
            bin_seen = bin;
            err_seen = out_err;
          end
        end
        chk("sweep_pulses", 16'(pulses), 16'd1);
        chk("sweep_bin", 16'(bin_seen), 16'(sum));
        chk("sweep_err", 16'(err_seen), 16'h0);
      end
    end

    // Reset two clocks after a change, then report the held pair after release.
    seg1 = 8'h07;
    seg0 = 8'h07;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst_async");
    tick();
    tick();
    chk_zero("midrst_held");
    rst_n = 1'b1;
    expect_report("midrst_77", 4'd7, 4'd7, 7'd77, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
